// File: rtl/sccb_write_arbiter.sv
// Round-robin arbiter that shares one SCCB master between two register-write requesters.
// Optional macro SCCB_RETRY_EN: re-run a failed write up to MAX_RETRY extra times.
//
//   state  | meaning
//   IDLE   | no transaction, waiting for req with master idle
//   START  | start condition with slave address, one cycle
//   W_ADDR | waiting for slave-address ack tick, then present register address
//   W_DATA | waiting for register-address ack tick, then present register data
//   W_STOP | waiting for data ack tick, then stop and report done
//   GAP    | mandatory idle after stop, then retry, report err, or return to IDLE
module sccb_write_arbiter #(
  parameter logic [7:0]  SLAVE_ADDR  = 8'h42,
  parameter int unsigned GAP_CYCLES  = 65536,
  parameter int unsigned ACK_TIMEOUT = 200000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [7:0] addr0,
  input  logic [7:0] data0,
  input  logic [7:0] addr1,
  input  logic [7:0] data1,
  output logic [1:0] grant,
  output logic [1:0] done,
  output logic [1:0] err,
  output logic       busy,
  output logic       start,
  output logic       stop,
  output logic [7:0] wr_data,
  input  logic [1:0] ack,
  input  logic [3:0] i2c_state
);

  localparam int unsigned TMAX = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
  localparam int          TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] ACK_LOAD = TW'(ACK_TIMEOUT - 1);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
`ifdef SCCB_RETRY_EN
  localparam int unsigned RETRY_LIMIT = MAX_RETRY;
`else
  // Without retry support every failure is final.
  localparam int unsigned RETRY_LIMIT = 0 * MAX_RETRY;
`endif
  localparam logic [RW-1:0] RETRY_MAX = RW'(RETRY_LIMIT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    W_ADDR = 3'd2,
    W_DATA = 3'd3,
    W_STOP = 3'd4,
    GAP    = 3'd5
  } state_t;

  state_t        state_q;
  logic          owner_q;
  logic [7:0]    addr_q;
  logic [7:0]    data_q;
  logic [TW-1:0] timer_q;
  logic          fail_q;
  logic [RW-1:0] retry_q;

  logic waiting;
  logic ack_ok;
  logic ack_nack;
  logic timeout;
  logic fail_now;
  logic gap_exit;
  logic retry_ok;
  logic win_valid;
  logic win;

  always_comb begin
    waiting   = (state_q == W_ADDR) || (state_q == W_DATA) || (state_q == W_STOP);
    ack_ok    = (ack == 2'b11);
    ack_nack  = (ack == 2'b10);
    timeout   = waiting && !ack[1] && (timer_q == '0);
    fail_now  = waiting && (ack_nack || timeout);
    gap_exit  = (state_q == GAP) && (timer_q == '0) && (i2c_state == 4'd0);
    retry_ok  = fail_q && (retry_q < RETRY_MAX);
    win_valid = (state_q == IDLE) && (i2c_state == 4'd0) && (req != 2'b00);
    // On a tie the requester that was not served last wins.
    win       = (req == 2'b11) ? ~owner_q : req[1];
  end

  always_comb begin
    grant   = 2'b00;
    done    = 2'b00;
    err     = 2'b00;
    start   = 1'b0;
    stop    = 1'b0;
    wr_data = 8'h00;
    busy    = (state_q != IDLE);
    // grant is combinational on req, so hold it low while reset is asserted.
    if (rst_n && win_valid) grant = win ? 2'b10 : 2'b01;
    unique case (state_q)
      START: begin
        start   = 1'b1;
        wr_data = SLAVE_ADDR;
      end
      W_ADDR: if (ack_ok) wr_data = addr_q;
      W_DATA: if (ack_ok) wr_data = data_q;
      W_STOP: if (ack_ok) begin
        stop = 1'b1;
        done = owner_q ? 2'b10 : 2'b01;
      end
      GAP: if (gap_exit && fail_q && !retry_ok) err = owner_q ? 2'b10 : 2'b01;
      default: ;
    endcase
    if (fail_now) stop = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b1;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
      timer_q <= '0;
      fail_q  <= 1'b0;
      retry_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (win_valid) begin
            owner_q <= win;
            addr_q  <= win ? addr1 : addr0;
            data_q  <= win ? data1 : data0;
            fail_q  <= 1'b0;
            retry_q <= '0;
            state_q <= START;
          end
        end
        START: begin
          timer_q <= ACK_LOAD;
          state_q <= W_ADDR;
        end
        W_ADDR, W_DATA, W_STOP: begin
          if (fail_now) begin
            fail_q  <= 1'b1;
            timer_q <= GAP_LOAD;
            state_q <= GAP;
          end else if (ack_ok) begin
            unique case (state_q)
              W_ADDR: begin
                timer_q <= ACK_LOAD;
                state_q <= W_DATA;
              end
              W_DATA: begin
                timer_q <= ACK_LOAD;
                state_q <= W_STOP;
              end
              default: begin
                fail_q  <= 1'b0;
                timer_q <= GAP_LOAD;
                state_q <= GAP;
              end
            endcase
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        GAP: begin
          if (timer_q != '0) timer_q <= timer_q - TW'(1);
          if (gap_exit) begin
            if (retry_ok) begin
              retry_q <= retry_q + RW'(1);
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
